// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the pipeline stage buffer: the occupancy register doubles as FSM state.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and optional skid slot.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int              WIDTH  = 32,
  parameter bit              SKID   = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_fire, out_fire;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= BUBBLE;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_q, skid_d;

      // Ready depends only on the state flop, cutting the stall path from downstream.
      assign in_ready = !rst & !flush & (occ_q != OCC_FULL);

      always_ff @(posedge clk) begin
        if (rst) skid_q <= BUBBLE;
        else     skid_q <= skid_d;
      end

      always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
          occ_d  = OCC_EMPTY;
          main_d = BUBBLE;
          skid_d = BUBBLE;
        end else begin
          case (occ_q)
            OCC_EMPTY: begin
              if (in_fire) begin
                occ_d  = OCC_ONE;
                main_d = in_data;
              end
            end
            OCC_ONE: begin
              if (in_fire && out_fire) begin
                main_d = in_data;
              end else if (in_fire) begin
                occ_d  = OCC_FULL;
                skid_d = in_data;
              end else if (out_fire) begin
                occ_d  = OCC_EMPTY;
                main_d = BUBBLE;
              end
            end
            OCC_FULL: begin
              if (out_fire) begin
                occ_d  = OCC_ONE;
                main_d = skid_q;
                skid_d = BUBBLE;
              end
            end
            default: begin
              occ_d  = OCC_EMPTY;
              main_d = BUBBLE;
              skid_d = BUBBLE;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready = !rst & !flush & (!out_valid | out_ready);

      always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        if (flush) begin
          occ_d  = OCC_EMPTY;
          main_d = BUBBLE;
        end else if (in_fire) begin
          occ_d  = OCC_ONE;
          main_d = in_data;
        end else if (out_fire) begin
          occ_d  = OCC_EMPTY;
          main_d = BUBBLE;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a skid (SKID=1) and a single-entry (SKID=0) stage in lockstep against bounded-FIFO reference models.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  bit          last_push1;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .SKID(1'b1), .BUBBLE(32'h0)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_buf #(.WIDTH(32), .SKID(1'b0), .BUBBLE(32'h0)) u_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Acceptance rule of a stage holding 'size' of at most 'cap' bundles.
  function automatic bit exp_ready(int cap, int size);
    if (rst || flush) return 1'b0;
    if (cap == 2) return size < 2;
    return (size == 0) || out_ready;
  endfunction

  // Check outputs mid-cycle, advance the models, then step past the next edge.
  task automatic cycle();
    bit r1, r0;
    @(negedge clk);
    r1 = exp_ready(2, q1.size());
    r0 = exp_ready(1, q0.size());
    chk("s1_in_ready",  {31'b0, in_ready1},  {31'b0, r1});
    chk("s1_out_valid", {31'b0, out_valid1}, {31'b0, q1.size() > 0});
    chk("s1_out_data",  out_data1, (q1.size() > 0) ? q1[0] : 32'h0);
    chk("s1_occ",       {30'b0, occ1}, 32'(q1.size()));
    chk("s0_in_ready",  {31'b0, in_ready0},  {31'b0, r0});
    chk("s0_out_valid", {31'b0, out_valid0}, {31'b0, q0.size() > 0});
    chk("s0_out_data",  out_data0, (q0.size() > 0) ? q0[0] : 32'h0);
    chk("s0_occ",       {30'b0, occ0}, 32'(q0.size()));
    last_push1 = 1'b0;
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_ready && q1.size() > 0) void'(q1.pop_front());
      if (in_valid && r1) begin q1.push_back(in_data); last_push1 = 1'b1; end
      if (out_ready && q0.size() > 0) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; flush = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    // stall with three bundles, then release
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; cycle();
    in_data = 32'hB; cycle();
    in_data = 32'hC; cycle();
    chk("stall_occ", {30'b0, occ1}, 32'd2);
    chk("stall_hold", out_data1, 32'hA);
    cycle();
    out_ready = 1'b1;
    begin
      int n = 0;
      do begin cycle(); n++; end while (!last_push1 && n < 8);
      chk("stall_c_accept", {31'b0, last_push1}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (4) cycle();

    // flush while full
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; cycle();
    in_data = 32'hB; cycle();
    in_data = 32'hC; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("flush_valid", {31'b0, out_valid1}, 32'd0);
    repeat (3) cycle();

    // single-entry stage: release of a stall opens ready combinationally
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h5; cycle();
    in_data = 32'h6; cycle();
    out_ready = 1'b1; cycle();
    in_valid = 1'b0; cycle();
    chk("s0_next_data_was", q0.size() == 0 ? 32'h0 : q0[0], 32'h0);
    repeat (2) cycle();

    // random traffic
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
